// File: rtl/trace_stream_arbiter.sv
// Two-input, packet-atomic round-robin arbiter merging trace flit streams,
// with a configurable idle gap inserted after every forwarded packet.
module trace_stream_arbiter #(
    parameter int unsigned GAP_CYCLES = 2,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in0_valid,
    output logic                 in0_ready,
    input  logic [63:0]          in0_bits_data,
    input  logic [7:0]           in0_bits_keep,
    input  logic                 in0_bits_last,
    input  logic                 in1_valid,
    output logic                 in1_ready,
    input  logic [63:0]          in1_bits_data,
    input  logic [7:0]           in1_bits_keep,
    input  logic                 in1_bits_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [63:0]          out_bits_data,
    output logic [7:0]           out_bits_keep,
    output logic                 out_bits_last,
    output logic                 out_src,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] pkt_count
);
    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } flit_t;

    typedef enum logic [1:0] {IDLE, LOCK, GAP} state_t;

    localparam logic [3:0] GAP_INIT = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    state_t         state;
    logic           grant;
    logic           rr_ptr;
    logic [3:0]     gap_cnt;
    logic [1:0]     in_valid;
    flit_t [1:0]    in_flit;
    flit_t          out_flit;
    logic           locked;
    logic           xfer;

    assign in_valid   = {in1_valid, in0_valid};
    assign in_flit[0] = {in0_bits_data, in0_bits_keep, in0_bits_last};
    assign in_flit[1] = {in1_bits_data, in1_bits_keep, in1_bits_last};

    // Gating with reset keeps the handshake quiet before the state register clears.
    assign locked    = (state == LOCK) && !reset;
    assign out_flit  = locked ? in_flit[grant] : '0;
    assign out_valid = locked && in_valid[grant];
    assign in0_ready = locked && !grant && out_ready;
    assign in1_ready = locked && grant && out_ready;
    assign xfer      = out_valid && out_ready;

    assign {out_bits_data, out_bits_keep, out_bits_last} = out_flit;
    assign out_src = grant;
    assign busy    = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= 1'b0;
            rr_ptr    <= 1'b0;
            gap_cnt   <= '0;
            pkt_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|in_valid) begin
                        grant <= in_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
                        state <= LOCK;
                    end
                end
                LOCK: begin
                    // Grant is only released by the transfer of an end-of-packet flit.
                    if (xfer && out_flit.last) begin
                        rr_ptr    <= ~grant;
                        pkt_count <= pkt_count + CNT_WIDTH'(1);
                        if (GAP_CYCLES > 0) begin
                            state   <= GAP;
                            gap_cnt <= GAP_INIT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) state <= IDLE;
                    else               gap_cnt <= gap_cnt - 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_trace_stream_arbiter.sv
// Scoreboarded bench for trace_stream_arbiter: two instances (default gap and
// zero gap with a 4-bit counter) driven by randomized packet traffic.
module tb_trace_stream_arbiter;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned GAP = (g == 0) ? 2 : 0;
        localparam int unsigned CW  = (g == 0) ? 32 : 4;

        logic        reset = 1'b1;
        logic        vld [2];
        logic [63:0] dat [2];
        logic [7:0]  kp  [2];
        logic        lst [2];
        logic        out_ready = 1'b1;
        wire  [1:0]  rdy;
        wire         ov, ol, osrc, bsy;
        wire  [63:0] od;
        wire  [7:0]  okp;
        wire  [CW-1:0] cnt;

        int          plen_q [2][$];
        logic [63:0] dq     [2][$];
        logic [72:0] expq   [2][$];
        int          rdy_mode = 0;
        bit          bubbles = 0;

        // Reference model: pending-packet queues plus the arbitration rules.
        int cyc = 0, idle_from = 0, pc = 0;
        int xfers [2] = '{0, 0};
        bit in_pkt = 0, src = 0, pref = 0, quiet = 1;

        trace_stream_arbiter #(.GAP_CYCLES(GAP), .CNT_WIDTH(CW)) dut (
            .clock(clock), .reset(reset),
            .in0_valid(vld[0]), .in0_ready(rdy[0]), .in0_bits_data(dat[0]),
            .in0_bits_keep(kp[0]), .in0_bits_last(lst[0]),
            .in1_valid(vld[1]), .in1_ready(rdy[1]), .in1_bits_data(dat[1]),
            .in1_bits_keep(kp[1]), .in1_bits_last(lst[1]),
            .out_valid(ov), .out_ready(out_ready), .out_bits_data(od),
            .out_bits_keep(okp), .out_bits_last(ol), .out_src(osrc),
            .busy(bsy), .pkt_count(cnt)
        );

        always @(posedge clock) begin
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = !out_ready;
            endcase
        end

        always @(negedge clock) begin
            logic [72:0] e;
            cyc++;
            if (reset) begin
                chk("reset_out_valid", ov, 0);
                chk("reset_readies", rdy, 0);
                in_pkt = 0; src = 0; pref = 0; pc = 0; idle_from = 0;
                expq[0].delete();
                expq[1].delete();
            end else begin
                chk("out_src", osrc, src);
                chk("pkt_count", cnt, longint'(pc) % (longint'(1) << CW));
                if (!in_pkt) begin
                    chk("idle_out_valid", ov, 0);
                    chk("idle_readies", rdy, 0);
                    chk("idle_bits_zero", {od, okp, ol}, 0);
                    chk("idle_busy", bsy, cyc < idle_from);
                    if (cyc >= idle_from && (vld[0] || vld[1])) begin
                        src    = vld[pref] ? pref : !pref;
                        in_pkt = 1;
                    end
                end else begin
                    chk("lock_busy", bsy, 1);
                    chk("lock_out_valid", ov, vld[src]);
                    chk("lock_readies", rdy, out_ready ? (2'b01 << src) : 2'b00);
                    if (vld[src] && out_ready) begin
                        xfers[src]++;
                        chk("flit_expected", expq[src].size() != 0, 1);
                        if (expq[src].size() != 0) begin
                            e = expq[src].pop_front();
                            chk("flit_payload", {od, okp, ol}, e);
                            if (e[0]) begin
                                pc++;
                                pref      = !src;
                                in_pkt    = 0;
                                idle_from = cyc + 1 + GAP;
                            end
                        end
                    end
                end
            end
            quiet = !in_pkt && plen_q[0].size() == 0 && plen_q[1].size() == 0;
        end

        for (genvar s = 0; s < 2; s++) begin : g_drv
            initial begin
                int          n;
                logic [63:0] d;
                logic [7:0]  k;
                bit          aborted;
                vld[s] = 0; dat[s] = '0; kp[s] = '0; lst[s] = 0;
                @(posedge clock); #2;
                forever begin
                    if (reset || plen_q[s].size() == 0) begin
                        @(posedge clock); #2;
                        continue;
                    end
                    n = plen_q[s][0];
                    aborted = 0;
                    for (int f = 0; f < n && !aborted; f++) begin
                        if (dq[s].size() != 0) begin
                            d = dq[s].pop_front(); k = 8'hFF;
                        end else begin
                            d = {$urandom, $urandom}; k = 8'($urandom_range(1, 255));
                        end
                        vld[s] = 1; dat[s] = d; kp[s] = k; lst[s] = (f == n - 1);
                        expq[s].push_back({d, k, f == n - 1});
                        do @(negedge clock); while (!rdy[s] && !reset);
                        aborted = reset;
                        @(posedge clock); #2;
                        vld[s] = 0;
                        if (bubbles && !aborted)
                            repeat ($urandom_range(0, 2)) begin @(posedge clock); #2; end
                    end
                    while (reset) begin @(posedge clock); #2; end
                    void'(plen_q[s].pop_front());
                    if (bubbles) repeat ($urandom_range(0, 3)) begin @(posedge clock); #2; end
                end
            end
        end
    end

    task automatic set_reset(input int d, input logic v);
        if (d == 0) g_dut[0].reset = v;
        else        g_dut[1].reset = v;
    endtask

    task automatic pulse_reset(input int d);
        @(posedge clock); #1;
        set_reset(d, 1'b1);
        repeat (2) @(posedge clock);
        #1;
        set_reset(d, 1'b0);
    endtask

    task automatic wait_quiet(input int d, input int budget);
        int n = 0;
        @(negedge clock); #1;
        while (!(d == 0 ? g_dut[0].quiet : g_dut[1].quiet) && n < budget) begin
            @(negedge clock); #1;
            n++;
        end
        n_checks++;
        if (n >= budget) begin
            n_fail++;
            $display("FAIL wait_quiet dut%0d: traffic not drained after %0d cycles", d, budget);
        end
    endtask

    initial begin
        int st, n;
        // Both inputs hold a 3-flit packet from reset release.
        g_dut[0].plen_q[0].push_back(3);
        g_dut[0].plen_q[1].push_back(3);
        repeat (2) @(posedge clock);
        #1;
        set_reset(0, 1'b0);
        set_reset(1, 1'b0);
        wait_quiet(0, 100);
        chk("two_pkt_count", g_dut[0].cnt, 2);
        chk("two_pkt_last_src", g_dut[0].osrc, 1);

        // Single-flit packet from in1 only.
        pulse_reset(0);
        g_dut[0].dq[1].push_back(64'h0123456789ABCDEF);
        g_dut[0].plen_q[1].push_back(1);
        wait_quiet(0, 100);
        chk("single_flit_count", g_dut[0].cnt, 1);

        // out_ready toggling while in0 holds a 4-flit grant, in1 waiting.
        g_dut[0].rdy_mode = 2;
        g_dut[0].plen_q[0].push_back(4);
        g_dut[0].plen_q[1].push_back(3);
        wait_quiet(0, 200);
        g_dut[0].rdy_mode = 0;

        // Reset lands on flit 2 of a 4-flit in1 packet.
        g_dut[0].plen_q[1].push_back(4);
        st = g_dut[0].xfers[1];
        n = 0;
        while (g_dut[0].xfers[1] == st && n < 100) begin @(negedge clock); #1; n++; end
        chk("mid_reset_first_flit", g_dut[0].xfers[1] != st, 1);
        pulse_reset(0);
        @(negedge clock); #1;
        chk("mid_reset_count", g_dut[0].cnt, 0);
        chk("mid_reset_src", g_dut[0].osrc, 0);
        chk("mid_reset_busy", g_dut[0].bsy, 0);
        g_dut[0].plen_q[0].push_back(1);
        g_dut[0].plen_q[1].push_back(1);
        wait_quiet(0, 100);
        chk("post_reset_count", g_dut[0].cnt, 2);

        // Randomized traffic with bubbles and random backpressure.
        g_dut[0].bubbles  = 1;
        g_dut[0].rdy_mode = 1;
        for (int i = 0; i < 25; i++) begin
            g_dut[0].plen_q[0].push_back($urandom_range(1, 4));
            g_dut[0].plen_q[1].push_back($urandom_range(1, 4));
        end
        wait_quiet(0, 6000);

        // Zero-gap instance: back-to-back packets from in0.
        g_dut[1].plen_q[0].push_back(2);
        g_dut[1].plen_q[0].push_back(1);
        g_dut[1].plen_q[0].push_back(3);
        g_dut[1].plen_q[0].push_back(1);
        wait_quiet(1, 200);
        chk("zero_gap_count", g_dut[1].cnt, 4);

        // 17 single-flit packets wrap a 4-bit counter to 1.
        pulse_reset(1);
        for (int i = 0; i < 17; i++) g_dut[1].plen_q[i % 2].push_back(1);
        wait_quiet(1, 300);
        chk("wrap_count", g_dut[1].cnt, 1);

        @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
